jk_excitation_driver: RTL

- Drives an external jk_ff from a stream of desired next-state bits; the stream is the opposite direction of the flop's J/K → Q behaviour.
- For each target bit, derives the J/K excitation from its internal model of the current Q, drives one J/K command, and checks the flop's returned Q.
- Buffers targets in a small FIFO and counts mismatches.
- Used as a self-checking stimulus source around jk_ff in benches and small sequencer designs.

---
 rtl/jk_excitation_driver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - queued J/K excitation driver that checks the driven flop's Q
// Optional: define JK_TOGGLE_EXC_EN to resolve excitation don't-cares to toggle/hold form.
module jk_excitation_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             exp_q,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {CLR = 2'd0, IDLE = 2'd1, DRIVE = 2'd2, CHECK = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             tgt_q, tgt_d;
  logic             j_q, j_d, k_q, k_d;
  logic             exp_q_q, exp_q_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             full, empty, push, pop, head, exc_j, exc_k;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign tgt_ready = !full && (state_q != CLR);
  assign push      = tgt_valid && tgt_ready;
  assign pop       = (state_q == IDLE) && !empty;
  assign head      = mem_q[rd_ptr_q];

  // Excitation for the transition exp_q -> head.
  always_comb begin
    exc_j = 1'b0;
    exc_k = 1'b0;
`ifdef JK_TOGGLE_EXC_EN
    exc_j = exp_q_q ^ head;
    exc_k = exp_q_q ^ head;
`else
    exc_j = !exp_q_q && head;
    exc_k = exp_q_q && !head;
`endif
  end

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tgt_d    = tgt_q;
    j_d      = 1'b0;
    k_d      = 1'b0;
    exp_q_d  = exp_q_q;
    mis_d    = 1'b0;
    err_d    = err_q;
    if (push) begin
      mem_d[wr_ptr_q] = tgt_bit;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    case (state_q)
      CLR:   state_d = IDLE;
      IDLE: begin
        if (pop) begin
          tgt_d   = head;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        // Resync the model to the real flop so one fault does not cascade.
        exp_q_d = q_fb;
        if (q_fb != tgt_q) begin
          mis_d = 1'b1;
          if (err_q != '1) err_d = err_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLR;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tgt_q    <= 1'b0;
      j_q      <= 1'b0;
      k_q      <= 1'b1;
      exp_q_q  <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tgt_q    <= tgt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      exp_q_q  <= exp_q_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
    end
  end

  assign j        = j_q;
  assign k        = k_q;
  assign exp_q    = exp_q_q;
  assign mismatch = mis_q;
  assign err_cnt  = err_q;
  assign busy     = (state_q != IDLE) || !empty;
endmodule
